// File: rtl/universal_shift_register_if.sv
// ============================================================================
// Module   : universal_shift_register_if
// Brief    : Control/data bundle between a control unit and the shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface universal_shift_register_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] Result;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] shift_count;
    logic             frame_done;

    modport master (
        output en, mode, sin_r, sin_l, pdata,
        input  Result, sout_r, sout_l, shift_count, frame_done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, pdata,
        output Result, sout_r, sout_l, shift_count, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/universal_shift_register.sv
// ============================================================================
// Module   : universal_shift_register
// Brief    : WIDTH-bit hold/shift-right/shift-left/load register with frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_shift_register #(
    parameter int WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    universal_shift_register_if.slave  bus
);
    localparam int         CNT_W      = $clog2(WIDTH + 1);
    localparam logic [1:0] c_MODE_SHR = 2'b01;
    localparam logic [1:0] c_MODE_SHL = 2'b10;
    localparam logic [1:0] c_MODE_LD  = 2'b11;

    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_count;
    logic             r_frame_done;

    logic [WIDTH-1:0] w_result_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_frame_done_nxt;
    logic             w_shift;

    always_comb begin
        w_result_nxt     = r_result;
        w_count_nxt      = r_count;
        w_frame_done_nxt = 1'b0;
        w_shift          = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                c_MODE_SHR: begin
                    w_result_nxt = {bus.sin_r, r_result[WIDTH-1:1]};
                    w_shift      = 1'b1;
                end
                c_MODE_SHL: begin
                    w_result_nxt = {r_result[WIDTH-2:0], bus.sin_l};
                    w_shift      = 1'b1;
                end
                c_MODE_LD: begin
                    w_result_nxt = bus.pdata;
                    w_count_nxt  = '0;
                end
                default: ;
            endcase
        end
        // Shifts in either direction share one frame count; the WIDTH-th wraps it.
        if (w_shift) begin
            if (r_count == CNT_W'(WIDTH - 1)) begin
                w_count_nxt      = '0;
                w_frame_done_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result     <= '0;
            r_count      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_result     <= w_result_nxt;
            r_count      <= w_count_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.Result      = r_result;
    assign bus.sout_r      = r_result[0];
    assign bus.sout_l      = r_result[WIDTH-1];
    assign bus.shift_count = r_count;
    assign bus.frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// Module   : tb_universal_shift_register
// Brief    : Scenario bench for 8-bit and 4-bit shifter instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_register;
    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst4 = 1'b1;
    always #5 clk = ~clk;

    universal_shift_register_if #(.WIDTH(8)) b8 ();
    universal_shift_register_if #(.WIDTH(4)) b4 ();

    universal_shift_register #(.WIDTH(8)) u_dut8 (.clk(clk), .reset(rst8), .bus(b8.slave));
    universal_shift_register #(.WIDTH(4)) u_dut4 (.clk(clk), .reset(rst4), .bus(b4.slave));

    typedef struct packed { logic [7:0] res; logic [3:0] cnt; logic fd; } exp8_t;
    typedef struct packed { logic [3:0] res; logic [2:0] cnt; logic fd; } exp4_t;

    exp8_t      q8[$];
    exp4_t      q4[$];
    logic [7:0] m_res;
    logic [3:0] m_cnt;
    int         n_vec = 0;
    int         n_err = 0;

    // Reference behaviour of the 8-bit instance; expected state is queued, then one edge applied.
    task automatic cyc8(input logic r, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [7:0] pd);
        exp8_t x;
        logic  sh;
        rst8 = r; b8.en = e; b8.mode = m; b8.sin_r = sr; b8.sin_l = sl; b8.pdata = pd;
        sh   = 1'b0;
        x.fd = 1'b0;
        if (r) begin
            m_res = 8'h00;
            m_cnt = 4'd0;
        end else if (e) begin
            case (m)
                2'b01: begin m_res = {sr, m_res[7:1]}; sh = 1'b1; end
                2'b10: begin m_res = {m_res[6:0], sl}; sh = 1'b1; end
                2'b11: begin m_res = pd; m_cnt = 4'd0; end
                default: ;
            endcase
            if (sh) begin
                if (m_cnt == 4'd7) begin
                    m_cnt = 4'd0;
                    x.fd  = 1'b1;
                end else begin
                    m_cnt = m_cnt + 4'd1;
                end
            end
        end
        x.res = m_res;
        x.cnt = m_cnt;
        q8.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp8_t exp, got;
        cyc8(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'($urandom));
        cyc8(1'b0, 1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
        cyc8(1'b0, 1'b1, 2'b10, 1'b0, 1'($urandom), 8'h00);
        cyc8(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            exp = q8.pop_front();
            if (i == 3) exp = '{res: 8'h00, cnt: 4'd0, fd: 1'b0};
        end
        got = {b8.Result, b8.shift_count, b8.frame_done};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                     got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
        end
    endtask

    task automatic test_sipo_right();
        exp8_t      exp, got;
        logic [7:0] seq;
        seq = 8'b0100_1101;
        cyc8(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        void'(q8.pop_front());
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b0, 1'b1, 2'b01, seq[i], 1'($urandom), 8'($urandom));
            exp = q8.pop_front();
            got = {b8.Result, b8.shift_count, b8.frame_done};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL sipo_right[%0d]: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                         i, got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
            end
        end
        n_vec++;
        if ({b8.Result, b8.shift_count, b8.frame_done} !== {8'h4D, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL sipo_final: got res=%h cnt=%0d fd=%b, want res=4d cnt=0 fd=1",
                     b8.Result, b8.shift_count, b8.frame_done);
        end
    endtask

    task automatic test_piso_left();
        exp8_t      exp, got;
        logic [7:0] pat;
        pat = 8'hA5;
        cyc8(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, pat);
        void'(q8.pop_front());
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (b8.sout_l !== pat[7-i]) begin
                n_err++;
                $display("FAIL piso_sout_l[%0d]: got %b, want %b", i, b8.sout_l, pat[7-i]);
            end
            cyc8(1'b0, 1'b1, 2'b10, 1'($urandom), 1'b0, 8'($urandom));
            exp = q8.pop_front();
            got = {b8.Result, b8.shift_count, b8.frame_done};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL piso_left[%0d]: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                         i, got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
            end
        end
        n_vec++;
        if ({b8.Result, b8.frame_done} !== {8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL piso_final: got res=%h fd=%b, want res=00 fd=1", b8.Result, b8.frame_done);
        end
    endtask

    task automatic test_enable_gating();
        exp8_t exp, got;
        cyc8(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
        for (int i = 0; i < 3; i++) cyc8(1'b0, 1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 5; i++)
            cyc8(1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        for (int i = 0; i < 5; i++) cyc8(1'b0, 1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 14; i++) begin
            exp = q8.pop_front();
            if (i >= 4 && i <= 8) begin
                n_vec++;
                if (exp.cnt !== 4'd3 || exp.fd !== 1'b0) begin
                    n_err++;
                    $display("FAIL gate_model[%0d]: got cnt=%0d fd=%b, want cnt=3 fd=0", i, exp.cnt, exp.fd);
                end
            end
        end
        got = {b8.Result, b8.shift_count, b8.frame_done};
        n_vec++;
        if (got !== exp || got.fd !== 1'b1) begin
            n_err++;
            $display("FAIL gate_final: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=1",
                     got.res, got.cnt, got.fd, exp.res, exp.cnt);
        end
    endtask

    task automatic test_enable_frozen();
        exp8_t exp, got;
        cyc8(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
        void'(q8.pop_front());
        for (int i = 0; i < 13; i++) begin
            if (i >= 3 && i < 8)
                cyc8(1'b0, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            else
                cyc8(1'b0, 1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
            exp = q8.pop_front();
            got = {b8.Result, b8.shift_count, b8.frame_done};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL enable[%0d]: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                         i, got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
            end
        end
    endtask

    task automatic test_mixed_load();
        exp8_t exp, got;
        int    pulses;
        cyc8(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        for (int i = 0; i < 4; i++) cyc8(1'b0, 1'b1, 2'b10, 1'b0, 1'($urandom), 8'h00);
        for (int i = 0; i < 2; i++) cyc8(1'b0, 1'b1, 2'b01, 1'($urandom), 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            exp = q8.pop_front();
            got = {b8.Result, b8.shift_count, b8.frame_done};
        end
        n_vec++;
        if (got !== exp || got.cnt !== 4'd6) begin
            n_err++;
            $display("FAIL mixed_cnt6: got res=%h cnt=%0d fd=%b, want res=%h cnt=6 fd=%b",
                     got.res, got.cnt, got.fd, exp.res, exp.fd);
        end
        cyc8(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'($urandom));
        exp = q8.pop_front();
        got = {b8.Result, b8.shift_count, b8.frame_done};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL mixed_hold: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                     got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
        end
        cyc8(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 8'h0F);
        void'(q8.pop_front());
        n_vec++;
        if ({b8.Result, b8.shift_count, b8.frame_done} !== {8'h0F, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL mixed_load: got res=%h cnt=%0d fd=%b, want res=0f cnt=0 fd=0",
                     b8.Result, b8.shift_count, b8.frame_done);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc8(1'b0, 1'b1, (i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom), 1'($urandom), 8'h00);
            exp = q8.pop_front();
            got = {b8.Result, b8.shift_count, b8.frame_done};
            pulses += int'(b8.frame_done);
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL mixed_shift[%0d]: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                         i, got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
            end
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL mixed_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        exp4_t      exp, got;
        logic [3:0] res;
        logic       b;
        b4.en = 1'b0; b4.mode = 2'b00; b4.sin_r = 1'b0; b4.sin_l = 1'b0; b4.pdata = 4'h0;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        res  = 4'h0;
        for (int i = 0; i < 12; i++) begin
            b             = 1'($urandom);
            b4.en         = 1'b1;
            b4.mode       = 2'b01;
            b4.sin_r      = b;
            b4.sin_l      = 1'($urandom);
            b4.pdata      = 4'($urandom);
            res           = {b, res[3:1]};
            q4.push_back('{res: res, cnt: 3'((i + 1) % 4), fd: (i % 4 == 3)});
            @(posedge clk); #1;
            exp = q4.pop_front();
            got = {b4.Result, b4.shift_count, b4.frame_done};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL w4_b2b[%0d]: got res=%h cnt=%0d fd=%b, want res=%h cnt=%0d fd=%b",
                         i, got.res, got.cnt, got.fd, exp.res, exp.cnt, exp.fd);
            end
        end
        b4.en = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (b4.frame_done !== 1'b0 || b4.shift_count !== 3'd0) begin
            n_err++;
            $display("FAIL w4_idle: got cnt=%0d fd=%b, want cnt=0 fd=0", b4.shift_count, b4.frame_done);
        end
    endtask

    initial begin
        b8.en = 1'b0; b8.mode = 2'b00; b8.sin_r = 1'b0; b8.sin_l = 1'b0; b8.pdata = 8'h00;
        b4.en = 1'b0; b4.mode = 2'b00; b4.sin_r = 1'b0; b4.sin_l = 1'b0; b4.pdata = 4'h0;
        m_res = 8'h00;
        m_cnt = 4'd0;
        @(posedge clk); #1;
        rst8 = 1'b0;
        test_reset();
        test_sipo_right();
        test_piso_left();
        test_enable_gating();
        test_enable_frozen();
        test_mixed_load();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
